// File: rtl/ps2_pad_responder_if.sv
// Pad connector pins of the DualShock serial link.
// The host drives clock, select and command; the pad drives data, its enable and ack.
interface ps2_pad_responder_if;
    logic ps_clk;
    logic ps_sel_n;
    logic ps_mosi;
    logic ps_miso;
    logic ps_miso_oe;
    logic ps_ack_n;

    modport master (
        output ps_clk, ps_sel_n, ps_mosi,
        input  ps_miso, ps_miso_oe, ps_ack_n
    );

    modport slave (
        input  ps_clk, ps_sel_n, ps_mosi,
        output ps_miso, ps_miso_oe, ps_ack_n
    );
endinterface

// File: rtl/ps2_pad_responder.sv
// PlayStation pad emulator: answers host polls with latched button (and axis) state.
// Define PS2_PAD_ANALOG_EN for the 9-byte analog frame (ID 0x73); default is digital (ID 0x41).
module ps2_pad_responder #(
    parameter int unsigned ACK_DELAY = 100,
    parameter int unsigned ACK_WIDTH = 50
) (
    input  logic                      clk,
    input  logic                      resetn,
    ps2_pad_responder_if.slave        pad,
    input  logic               [15:0] btn_n,
    input  logic               [31:0] axes,
    output logic                      frame_done,
    output logic               [7:0]  last_cmd
);

`ifdef PS2_PAD_ANALOG_EN
    localparam logic [7:0] IdByte   = 8'h73;
    localparam logic [3:0] LastByte = 4'd8;
`else
    localparam logic [7:0] IdByte   = 8'h41;
    localparam logic [3:0] LastByte = 4'd4;
`endif

    localparam int unsigned     CntW   = $clog2(ACK_DELAY + ACK_WIDTH + 1);
    localparam logic [CntW-1:0] AckOn  = CntW'(ACK_DELAY - 1);
    localparam logic [CntW-1:0] AckEnd = CntW'(ACK_DELAY + ACK_WIDTH - 1);

    typedef enum logic [2:0] {StIdle, StShift, StAck, StIgnore, StDone} state_e;

    state_e          state_q, state_d;
    logic [2:0]      ps_clk_sync_q, ps_sel_sync_q;
    logic [1:0]      ps_mosi_sync_q;
    logic [3:0]      byte_idx_q, byte_idx_d;
    logic [2:0]      bit_idx_q, bit_idx_d;
    logic [6:0]      rx_q, rx_d;
    logic [7:0]      tx_q, tx_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            miso_q, miso_d;
    logic            ack_q, ack_d;
    logic            frame_done_q, frame_done_d;
    logic [7:0]      last_cmd_q, last_cmd_d;
    logic [15:0]     btn_q;
    logic            latch_en;
    logic [7:0]      rx_byte, next_tx;
    logic [3:0]      nxt_idx;
    logic            clk_fall, clk_rise, sel_fall, sel_rise;

    // Select resets to "asserted" so a frame in progress at reset release yields no fall edge.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ps_clk_sync_q  <= 3'b111;
            ps_sel_sync_q  <= 3'b000;
            ps_mosi_sync_q <= 2'b11;
        end else begin
            ps_clk_sync_q  <= {ps_clk_sync_q[1:0], pad.ps_clk};
            ps_sel_sync_q  <= {ps_sel_sync_q[1:0], pad.ps_sel_n};
            ps_mosi_sync_q <= {ps_mosi_sync_q[0], pad.ps_mosi};
        end
    end

    assign clk_fall = ps_clk_sync_q[2] & ~ps_clk_sync_q[1];
    assign clk_rise = ~ps_clk_sync_q[2] & ps_clk_sync_q[1];
    assign sel_fall = ps_sel_sync_q[2] & ~ps_sel_sync_q[1];
    assign sel_rise = ~ps_sel_sync_q[2] & ps_sel_sync_q[1];
    assign rx_byte  = {ps_mosi_sync_q[1], rx_q};
    assign nxt_idx  = byte_idx_q + 4'd1;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            btn_q <= 16'hFFFF;
        end else if (latch_en) begin
            btn_q <= btn_n;
        end
    end

`ifdef PS2_PAD_ANALOG_EN
    logic [31:0] axes_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            axes_q <= 32'h8080_8080;
        end else if (latch_en) begin
            axes_q <= axes;
        end
    end
`else
    logic unused_axes;
    assign unused_axes = ^axes;
`endif

    always_comb begin
        next_tx = 8'hFF;
        case (nxt_idx)
            4'd1:    next_tx = IdByte;
            4'd2:    next_tx = 8'h5A;
            4'd3:    next_tx = btn_q[7:0];
            4'd4:    next_tx = btn_q[15:8];
`ifdef PS2_PAD_ANALOG_EN
            4'd5:    next_tx = axes_q[7:0];
            4'd6:    next_tx = axes_q[15:8];
            4'd7:    next_tx = axes_q[23:16];
            4'd8:    next_tx = axes_q[31:24];
`endif
            default: next_tx = 8'hFF;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        byte_idx_d   = byte_idx_q;
        bit_idx_d    = bit_idx_q;
        rx_d         = rx_q;
        tx_d         = tx_q;
        cnt_d        = cnt_q;
        miso_d       = miso_q;
        ack_d        = 1'b1;
        frame_done_d = 1'b0;
        last_cmd_d   = last_cmd_q;
        latch_en     = 1'b0;

        if (sel_rise) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (sel_fall) begin
                        latch_en   = 1'b1;
                        tx_d       = 8'hFF;
                        miso_d     = 1'b1;
                        byte_idx_d = 4'd0;
                        bit_idx_d  = 3'd0;
                        state_d    = StShift;
                    end
                end
                StShift: begin
                    if (clk_fall) begin
                        miso_d = tx_q[bit_idx_q];
                    end else if (clk_rise) begin
                        rx_d      = rx_byte[7:1];
                        bit_idx_d = bit_idx_q + 3'd1;
                        if (bit_idx_q == 3'd7) begin
                            if (byte_idx_q == 4'd1) begin
                                last_cmd_d = rx_byte;
                            end
                            if (byte_idx_q == 4'd0 && rx_byte != 8'h01) begin
                                state_d = StIgnore;
                            end else if (byte_idx_q == LastByte) begin
                                frame_done_d = 1'b1;
                                state_d      = StDone;
                            end else begin
                                cnt_d   = '0;
                                state_d = StAck;
                            end
                        end
                    end
                end
                StAck: begin
                    cnt_d = cnt_q + CntW'(1);
                    // An early host clock cuts the ack short and goes straight to the next byte.
                    if (clk_fall || cnt_q == AckEnd) begin
                        byte_idx_d = nxt_idx;
                        tx_d       = next_tx;
                        miso_d     = next_tx[0];
                        state_d    = StShift;
                    end else if (cnt_q >= AckOn) begin
                        ack_d = 1'b0;
                    end
                end
                StIgnore, StDone: begin
                    state_d = state_q;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= StIdle;
            byte_idx_q   <= 4'd0;
            bit_idx_q    <= 3'd0;
            rx_q         <= 7'd0;
            tx_q         <= 8'hFF;
            cnt_q        <= '0;
            miso_q       <= 1'b1;
            ack_q        <= 1'b1;
            frame_done_q <= 1'b0;
            last_cmd_q   <= 8'h00;
        end else begin
            state_q      <= state_d;
            byte_idx_q   <= byte_idx_d;
            bit_idx_q    <= bit_idx_d;
            rx_q         <= rx_d;
            tx_q         <= tx_d;
            cnt_q        <= cnt_d;
            miso_q       <= miso_d;
            ack_q        <= ack_d;
            frame_done_q <= frame_done_d;
            last_cmd_q   <= last_cmd_d;
        end
    end

    assign pad.ps_miso    = miso_q;
    assign pad.ps_miso_oe = (state_q == StShift) || (state_q == StAck);
    assign pad.ps_ack_n   = ack_q;
    assign frame_done     = frame_done_q;
    assign last_cmd       = last_cmd_q;

endmodule

// File: tb/tb_ps2_pad_responder.sv
// Directed bench for ps2_pad_responder: host-side bit-banging of pad polls at 250 kHz.
module tb_ps2_pad_responder;

    localparam int unsigned AckDelay = 100;
    localparam int unsigned AckWidth = 50;
    localparam int          Half     = 50;
`ifdef PS2_PAD_ANALOG_EN
    localparam int         NumBytes = 9;
    localparam logic [7:0] IdByte   = 8'h73;
`else
    localparam int         NumBytes = 5;
    localparam logic [7:0] IdByte   = 8'h41;
`endif

    logic        clk = 1'b0;
    logic        resetn;
    logic [15:0] btn_n;
    logic [31:0] axes;
    logic        frame_done;
    logic [7:0]  last_cmd;
    int          errors = 0;
    int          checks = 0;
    int          fd_cnt = 0;

    ps2_pad_responder_if pad ();

    ps2_pad_responder #(
        .ACK_DELAY (AckDelay),
        .ACK_WIDTH (AckWidth)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .pad        (pad),
        .btn_n      (btn_n),
        .axes       (axes),
        .frame_done (frame_done),
        .last_cmd   (last_cmd)
    );

    always #20 clk = ~clk;

    // Counts high cycles, so a stretched pulse shows up as an extra count.
    always @(posedge clk) if (frame_done) fd_cnt <= fd_cnt + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] exp_byte(input int b, input logic [15:0] btn);
        case (b)
            0:       return 8'hFF;
            1:       return IdByte;
            2:       return 8'h5A;
            3:       return btn[7:0];
            4:       return btn[15:8];
            5:       return 8'h10;
            6:       return 8'h7F;
            7:       return 8'h80;
            8:       return 8'h80;
            default: return 8'hFF;
        endcase
    endfunction

    // Returns right after driving the last rising edge.
    task automatic xfer_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk);
            pad.ps_clk  = 1'b0;
            pad.ps_mosi = tx[i];
            repeat (Half) @(negedge clk);
            rx[i]      = pad.ps_miso;
            pad.ps_clk = 1'b1;
            if (i < nbits - 1) repeat (Half - 1) @(negedge clk);
        end
    endtask

    task automatic wait_ack(input string tag);
        int dly = 0;
        int wid = 0;
        for (int k = 1; k <= 4 * (AckDelay + AckWidth); k++) begin
            @(posedge clk); #1;
            if (!pad.ps_ack_n) begin
                dly = k;
                break;
            end
        end
        check_eq($sformatf("%s ack delay", tag), dly, AckDelay + 3);
        if (dly != 0) begin
            for (int k = 1; k <= 4 * AckWidth; k++) begin
                @(posedge clk); #1;
                if (pad.ps_ack_n) begin
                    wid = k;
                    break;
                end
            end
            check_eq($sformatf("%s ack width", tag), wid, AckWidth);
        end
        repeat (10) @(negedge clk);
    endtask

    task automatic no_ack(input string tag, input int cycles);
        int lows = 0;
        for (int k = 0; k < cycles; k++) begin
            @(posedge clk); #1;
            if (!pad.ps_ack_n) lows++;
        end
        check_eq($sformatf("%s no ack", tag), lows, 0);
    endtask

    task automatic open_sel(input string tag);
        @(negedge clk);
        pad.ps_sel_n = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        check_eq($sformatf("%s oe early", tag), pad.ps_miso_oe, 1'b0);
        @(posedge clk); #1;
        check_eq($sformatf("%s oe on", tag), pad.ps_miso_oe, 1'b1);
        check_eq($sformatf("%s miso bit0", tag), pad.ps_miso, 1'b1);
        repeat (Half) @(negedge clk);
    endtask

    task automatic close_sel(input string tag);
        repeat (Half) @(negedge clk);
        pad.ps_sel_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_eq($sformatf("%s oe off", tag), pad.ps_miso_oe, 1'b0);
        check_eq($sformatf("%s ack idle", tag), pad.ps_ack_n, 1'b1);
        repeat (2 * Half) @(negedge clk);
    endtask

    task automatic run_frame(input logic [7:0] b0, input logic [7:0] cmd1,
                             input logic [15:0] btn_exp, input int chg_byte,
                             input logic [15:0] chg_val, input string tag);
        int         fd0;
        logic [7:0] rx;
        logic [7:0] tx;
        bit         addr;
        fd0  = fd_cnt;
        addr = (b0 == 8'h01);
        open_sel(tag);
        for (int b = 0; b < NumBytes; b++) begin
            tx = (b == 0) ? b0 : (b == 1) ? cmd1 : 8'h00;
            if (b == chg_byte) btn_n = chg_val;
            xfer_bits(tx, 8, rx);
            if (addr) check_eq($sformatf("%s byte%0d", tag, b), rx, exp_byte(b, btn_exp));
            if (addr && b < NumBytes - 1) begin
                wait_ack($sformatf("%s byte%0d", tag, b));
            end else begin
                no_ack($sformatf("%s byte%0d", tag, b), AckDelay + AckWidth + 10);
                if (!addr) check_eq($sformatf("%s oe ignored b%0d", tag, b), pad.ps_miso_oe, 1'b0);
            end
        end
        if (addr) begin
            check_eq($sformatf("%s oe done", tag), pad.ps_miso_oe, 1'b0);
            xfer_bits(8'h00, 1, rx);
            no_ack($sformatf("%s extra clk", tag), 20);
            check_eq($sformatf("%s oe extra clk", tag), pad.ps_miso_oe, 1'b0);
        end
        close_sel(tag);
        check_eq($sformatf("%s frame_done count", tag), fd_cnt - fd0, addr ? 1 : 0);
    endtask

    initial begin
        int         fd0;
        int         seen;
        logic [7:0] rx;

        pad.ps_clk   = 1'b1;
        pad.ps_sel_n = 1'b1;
        pad.ps_mosi  = 1'b1;
        btn_n        = 16'hFEFF;
        axes         = 32'h8080_7F10;
        resetn       = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset miso", pad.ps_miso, 1'b1);
        check_eq("reset oe", pad.ps_miso_oe, 1'b0);
        check_eq("reset ack", pad.ps_ack_n, 1'b1);
        check_eq("reset frame_done", frame_done, 1'b0);
        check_eq("reset last_cmd", last_cmd, 8'h00);
        @(negedge clk);
        resetn = 1'b1;
        repeat (5) @(negedge clk);

        run_frame(8'h01, 8'h42, 16'hFEFF, -1, 16'h0000, "poll");
        check_eq("poll last_cmd", last_cmd, 8'h42);

        run_frame(8'h81, 8'h43, 16'hFEFF, -1, 16'h0000, "badaddr");
        check_eq("badaddr last_cmd", last_cmd, 8'h42);

        // Select abort after bit 3 of byte2.
        fd0 = fd_cnt;
        open_sel("abort");
        xfer_bits(8'h01, 8, rx);
        wait_ack("abort byte0");
        xfer_bits(8'h43, 8, rx);
        check_eq("abort byte1", rx, IdByte);
        wait_ack("abort byte1");
        xfer_bits(8'h00, 4, rx);
        repeat (Half) @(negedge clk);
        pad.ps_sel_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_eq("abort oe", pad.ps_miso_oe, 1'b0);
        check_eq("abort ack", pad.ps_ack_n, 1'b1);
        check_eq("abort last_cmd", last_cmd, 8'h43);
        repeat (2 * Half) @(negedge clk);
        check_eq("abort frame_done", fd_cnt - fd0, 0);
        run_frame(8'h01, 8'h42, 16'hFEFF, -1, 16'h0000, "post-abort");
        check_eq("post-abort last_cmd", last_cmd, 8'h42);

        // Buttons change mid-frame; the latched copy must hold until the next select.
        btn_n = 16'hFFFF;
        run_frame(8'h01, 8'h42, 16'hFFFF, 2, 16'h0000, "coh1");
        run_frame(8'h01, 8'h42, 16'h0000, -1, 16'h0000, "coh2");

        // Reset while ack is low.
        fd0  = fd_cnt;
        seen = 0;
        open_sel("rst");
        xfer_bits(8'h01, 8, rx);
        for (int k = 1; k <= 4 * (AckDelay + AckWidth); k++) begin
            @(posedge clk); #1;
            if (!pad.ps_ack_n) begin
                seen = 1;
                break;
            end
        end
        check_eq("rst ack seen", seen, 1);
        @(negedge clk);
        resetn = 1'b0;
        #1;
        check_eq("rst ack release", pad.ps_ack_n, 1'b1);
        check_eq("rst oe", pad.ps_miso_oe, 1'b0);
        check_eq("rst miso", pad.ps_miso, 1'b1);
        check_eq("rst last_cmd", last_cmd, 8'h00);
        repeat (5) @(negedge clk);
        resetn = 1'b1;
        for (int b = 1; b < NumBytes; b++) begin
            xfer_bits((b == 1) ? 8'h42 : 8'h00, 8, rx);
            no_ack($sformatf("rst rest b%0d", b), AckDelay + AckWidth + 10);
            check_eq($sformatf("rst rest oe b%0d", b), pad.ps_miso_oe, 1'b0);
        end
        repeat (Half) @(negedge clk);
        pad.ps_sel_n = 1'b1;
        repeat (2 * Half) @(negedge clk);
        check_eq("rst frame_done", fd_cnt - fd0, 0);
        check_eq("rst last_cmd kept", last_cmd, 8'h00);
        run_frame(8'h01, 8'h42, 16'h0000, -1, 16'h0000, "post-rst");
        check_eq("post-rst last_cmd", last_cmd, 8'h42);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
